// File: rtl/ray_normalize_tagged.sv
// ray_normalize_tagged
//   Normalizes a tagged ray direction. Each component is divided by the
//   vector length with one shared restoring divider. The three components
//   go through the divider one after another, and the tag is carried along
//   unchanged.
//
// Ports
//   clk        system clock; all state changes happen on its rising edge
//   reset      asynchronous, active-low reset
//   in_valid   TDL_in holds a beat
//   TDL_in     tag, signed direction {x,y,z}, unsigned len (len MSB is always 0)
//   in_ready   block is idle and can take a beat this cycle
//   in_drop    registered pulse: a beat arrived while the block was busy
//   out_valid  TD_out holds a normalized result
//   out_ready  downstream takes the result
//   TD_out     tag plus normalized signed Q-format direction
//   div_zero   qualifies TD_out: len was 0, so the direction was forced to 0
//   busy       block is not idle

package ray_norm_pkg;
    localparam int WIDTH    = 16;
    localparam int Q_BITS   = 8;
    localparam int TAG_SIZE = 64;

    typedef struct packed {
        logic signed [WIDTH-1:0] x;
        logic signed [WIDTH-1:0] y;
        logic signed [WIDTH-1:0] z;
    } Direction;

    typedef struct packed {
        logic [TAG_SIZE-1:0] tag;
        Direction            direction;
    } TaggedDirection;

    typedef struct packed {
        logic [TAG_SIZE-1:0] tag;
        Direction            direction;
        logic [WIDTH-1:0]    len;
    } TaggedDirection_len;
endpackage

// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a beat; in_ready high
// DIV   | dividing component comp_idx (0=x, 1=y, 2=z), ITER edges each
// DONE  | result presented; held until out_valid && out_ready
module ray_normalize_tagged
    import ray_norm_pkg::*;
#(
    parameter int WIDTH    = ray_norm_pkg::WIDTH,
    parameter int Q_BITS   = ray_norm_pkg::Q_BITS,
    parameter int TAG_SIZE = ray_norm_pkg::TAG_SIZE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  TaggedDirection_len TDL_in,
    output logic               in_ready,
    output logic               in_drop,
    output logic               out_valid,
    input  logic               out_ready,
    output TaggedDirection     TD_out,
    output logic               div_zero,
    output logic               busy
);

    localparam int ITER = WIDTH + Q_BITS;
    localparam int CW   = $clog2(ITER);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ITER-1:0] MAX_MAG = ITER'((2 ** (WIDTH - 1)) - 1);

    logic [1:0]              state;
    logic [1:0]              comp_idx;
    logic [CW-1:0]           iter_cnt;
    logic [ITER-1:0]         dvd;       // dividend shifts out the top, quotient shifts in the bottom
    logic [WIDTH-1:0]        rem;
    logic [WIDTH-1:0]        len_r;
    logic signed [WIDTH-1:0] src_x, src_y, src_z;
    logic [TAG_SIZE-1:0]     tag_r;
    logic signed [WIDTH-1:0] res_x, res_y, res_z;

    logic [WIDTH:0]          shifted;
    logic [WIDTH:0]          trial;
    logic                    q_bit;
    logic [WIDTH-1:0]        rem_next;
    logic [ITER-1:0]         quo_next;
    logic [WIDTH-1:0]        mag_sat;
    logic signed [WIDTH-1:0] src_cur;
    logic signed [WIDTH-1:0] src_following;
    logic [WIDTH-1:0]        result;

    // |c| << Q_BITS. The magnitude of the most negative value is still
    // exact as an unsigned WIDTH-bit number.
    function automatic logic [ITER-1:0] abs_dividend(input logic signed [WIDTH-1:0] c);
        logic [WIDTH-1:0] mag;
        mag = c[WIDTH-1] ? (~c + 1'b1) : c;
        return {mag, {Q_BITS{1'b0}}};
    endfunction

    always_comb begin
        shifted  = {rem, dvd[ITER-1]};
        trial    = shifted - {1'b0, len_r};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {dvd[ITER-2:0], q_bit};

        // Clamping to +max before the sign is restored keeps the output
        // range symmetric.
        mag_sat = (quo_next > MAX_MAG) ? MAX_MAG[WIDTH-1:0] : quo_next[WIDTH-1:0];

        src_cur       = src_x;
        src_following = src_y;
        case (comp_idx)
            2'd1: begin
                src_cur       = src_y;
                src_following = src_z;
            end
            2'd2: begin
                src_cur       = src_z;
                src_following = src_z;
            end
            default: begin
                src_cur       = src_x;
                src_following = src_y;
            end
        endcase

        result = src_cur[WIDTH-1] ? (~mag_sat + 1'b1) : mag_sat;
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);

    assign TD_out.tag         = tag_r;
    assign TD_out.direction.x = res_x;
    assign TD_out.direction.y = res_y;
    assign TD_out.direction.z = res_z;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            comp_idx <= 2'd0;
            iter_cnt <= '0;
            dvd      <= '0;
            rem      <= '0;
            len_r    <= '0;
            src_x    <= '0;
            src_y    <= '0;
            src_z    <= '0;
            tag_r    <= '0;
            res_x    <= '0;
            res_y    <= '0;
            res_z    <= '0;
            div_zero <= 1'b0;
            in_drop  <= 1'b0;
        end else begin
            in_drop <= in_valid && (state != S_IDLE);

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        tag_r    <= TDL_in.tag;
                        src_x    <= TDL_in.direction.x;
                        src_y    <= TDL_in.direction.y;
                        src_z    <= TDL_in.direction.z;
                        len_r    <= TDL_in.len;
                        comp_idx <= 2'd0;
                        rem      <= '0;
                        iter_cnt <= CW'(ITER - 1);
                        dvd      <= abs_dividend(TDL_in.direction.x);
                        if (TDL_in.len == '0) begin
                            res_x    <= '0;
                            res_y    <= '0;
                            res_z    <= '0;
                            div_zero <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            div_zero <= 1'b0;
                            state    <= S_DIV;
                        end
                    end
                end

                S_DIV: begin
                    if (iter_cnt == '0) begin
                        // Last quotient bit: store the result, then load the
                        // next component so the divider never idles.
                        case (comp_idx)
                            2'd0:    res_x <= result;
                            2'd1:    res_y <= result;
                            default: res_z <= result;
                        endcase
                        rem      <= '0;
                        iter_cnt <= CW'(ITER - 1);
                        dvd      <= abs_dividend(src_following);
                        if (comp_idx == 2'd2) begin
                            state <= S_DONE;
                        end else begin
                            comp_idx <= comp_idx + 2'd1;
                        end
                    end else begin
                        dvd      <= quo_next;
                        rem      <= rem_next;
                        iter_cnt <= iter_cnt - 1'b1;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ray_normalize_tagged.md
Name: ray_normalize_tagged

Overview:
- Downstream consumer of the tagged square-root stage.
- Takes a TaggedDirection_len beat (tag, ray direction, length) and divides each direction component by len using a shared sequential restoring divider.
- Emits a unit-length TaggedDirection with the tag preserved.
- Feeds the ray-traversal stages through a valid/ready handshake.

Parameters:
- WIDTH, `WIDTH (16): fixed-point word width of direction components and len.
- Q_BITS, `Q_BITS (8): fractional bits of the Q format.
- TAG_SIZE, 64: tag field width; must match the TaggedDirection / TaggedDirection_len typedefs.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  TDL_in holds a valid beat.
- TDL_in  in  TaggedDirection_len  tag, direction {x,y,z} (signed WIDTH each), len (unsigned, MSB always 0).
- in_ready  out  1  block can accept a beat this cycle.
- in_drop  out  1  one-cycle pulse: in_valid seen while in_ready low; the beat is lost.
- out_valid  out  1  TD_out holds a normalized result.
- out_ready  in  1  downstream accepts the result.
- TD_out  out  TaggedDirection  tag plus normalized direction {x,y,z}, signed Q format.
- div_zero  out  1  qualifies TD_out: len was 0.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (asynchronous assert, low):
  - state = IDLE, out_valid = 0, in_drop = 0, div_zero = 0, busy = 0.
  - TD_out = 0; internal counters and registers cleared.
  - A division in progress is abandoned; no output is produced for it.
- in_ready = (state == IDLE). It is combinational from state only.
- Accept:
  - in_valid && in_ready at a rising edge E0 latches tag, x, y, z and len.
  - Next state is DIV with component index = 0.
  - If len == 0, next state is DONE instead, with TD_out.direction = 0, tag kept and div_zero = 1. out_valid rises after E0, one cycle of latency.
- Drop: if in_valid is high while state != IDLE, in_drop = 1 for that cycle (registered, visible the next cycle). The beat is ignored.
- Division per component c:
  - Dividend = |c| << Q_BITS, WIDTH+Q_BITS bits unsigned. Divisor = len.
  - Restoring division, one quotient bit per edge, ITER = WIDTH+Q_BITS edges.
  - Quotient is truncated, i.e. rounded toward zero.
  - Saturate: if quotient > 2^(WIDTH-1)-1, clamp the magnitude to 2^(WIDTH-1)-1.
  - Sign restore: negate if c < 0, giving a symmetric range with no -2^(WIDTH-1).
  - On the ITER-th edge, write the result to the x, y or z output register.
  - Advance the index on that same edge: 0 to 1 to 2, then to DONE.
- Latency: out_valid = 1 after edge E0 + 3*ITER (72 cycles at the defaults). The divider never stalls.
- DONE:
  - out_valid = 1; TD_out and div_zero are held stable.
  - Held until out_valid && out_ready at an edge, then return to IDLE with out_valid = 0.
  - New input can be accepted no earlier than the edge after the handshake.
  - out_ready is ignored in all other states.
- TD_out.tag always equals the tag latched for the beat currently presented; beats never reorder.
- Throughput: one beat per 3*ITER + 2 cycles. The upstream must be throttled, or rely on in_drop for detection.

Test Plan:
- Reset asserted mid-DIV (after 10 iterations) -> out_valid = 0, busy = 0 and in_ready = 1 immediately. No output appears for the abandoned beat.
- len = 256 (1.0), dir = (128, -64, 256), tag = 0xA5 -> after 72 cycles TD_out = (128, -64, 256), tag 0xA5, div_zero = 0.
- len = 1280 (5.0), dir = (768, -1024, 0), tag = 7 -> TD_out = (153, -204, 0), tag 7.
- len = 0, dir = (100, 100, 100) -> out_valid one cycle after accept, TD_out.direction = 0, div_zero = 1, tag preserved.
- len = 1, dir = (32767, -32768, 1) -> TD_out = (32767, -32767, 256). Covers saturation and the symmetric negative clamp.
- out_ready held low for 20 cycles after DONE, with a second in_valid pulse during DIV:
  - in_drop pulses once.
  - TD_out stays stable for the whole stall.
  - in_ready = 1 only on the cycle after out_ready rises and the handshake completes.
